// File: rtl/dmem_access_ctrl_if.sv
// Requester handshake bundle for dmem_access_ctrl.
// One instance per requester port (core LSU, debug/DMA).
interface dmem_access_ctrl_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output valid, we, op, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  valid, we, op, addr, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Round-robin two-requester sequencer in front of data_mem.
// Word-read loads with local extension, byte-split misaligned stores.
module dmem_access_ctrl #(
  parameter int MEM_SIZE_KB = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_access_ctrl_if.slave r0,
  dmem_access_ctrl_if.slave r1,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [2:0]        mem_op,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_datain,
  input  logic [31:0]       mem_dataout
);
  localparam logic [32:0] MEM_DEPTH = 33'(MEM_SIZE_KB * 1024);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  logic [1:0]  state;
  logic        rr_last;
  logic        gnt;
  logic        we_q;
  logic        err_q;
  logic        split_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;
  logic [31:0] rdata_q;
  logic [1:0]  step;
  logic [1:0]  last_q;

  logic        gnt0;
  logic        gnt1;
  logic        accept;
  logic        s_we;
  logic [2:0]  s_op;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [32:0] s_size;
  logic [2:0]  s_end;
  logic        s_err;
  logic        s_split;
  logic [1:0]  s_last;

  // rr_last=1 means r1 was granted last, so r0 wins a tie
  assign gnt0 = (state == S_IDLE) && r0.valid
              && (!r1.valid || rr_last);
  assign gnt1 = (state == S_IDLE) && r1.valid
              && (!r0.valid || !rr_last);
  assign accept = gnt0 || gnt1;

  assign r0.ready = gnt0;
  assign r1.ready = gnt1;

  assign s_we    = gnt1 ? r1.we    : r0.we;
  assign s_op    = gnt1 ? r1.op    : r0.op;
  assign s_addr  = gnt1 ? r1.addr  : r0.addr;
  assign s_wdata = gnt1 ? r1.wdata : r0.wdata;

  always_comb begin
    s_size  = 33'd4;
    s_last  = 2'd0;
    s_split = 1'b0;
    unique case (1'b1)
      s_op[1:0] == 2'b00: s_size = 33'd1;
      s_op[1:0] == 2'b01: s_size = 33'd2;
      default:            s_size = 33'd4;
    endcase
    s_end = {1'b0, s_addr[1:0]} + s_size[2:0];
    s_err = (({1'b0, s_addr} + s_size) > MEM_DEPTH)
          || (s_we ? (s_op > OP_W)
                   : (s_op == 3'b011 || s_op[2:1] == 2'b11));
    unique case (1'b1)
      !s_we: s_last = (s_end > 3'd4) ? 2'd1 : 2'd0;
      s_we && s_op == OP_H && s_addr[0]: begin
        s_last  = 2'd1;
        s_split = 1'b1;
      end
      s_we && s_op == OP_W && s_addr[1:0] != 2'b00: begin
        s_last  = 2'd3;
        s_split = 1'b1;
      end
      default: ;
    endcase
  end

  logic        in_acc;
  logic [63:0] word64;
  logic [31:0] sh;
  logic [31:0] ld_res;

  assign in_acc = (state == S_ACCESS);

  always_comb begin
    mem_read_en  = in_acc && !we_q;
    mem_write_en = in_acc && we_q;
    mem_op       = 3'd0;
    mem_addr     = 32'd0;
    mem_datain   = 32'd0;
    if (in_acc) begin
      unique case (1'b1)
        !we_q: begin
          mem_op   = OP_W;
          mem_addr = {addr_q[31:2], 2'b00}
                   + {28'd0, step, 2'b00};
        end
        we_q && split_q: begin
          mem_op     = OP_B;
          mem_addr   = addr_q + {30'd0, step};
          mem_datain = (wdata_q >> {step, 3'b000})
                     & 32'h0000_00FF;
        end
        default: begin
          mem_op     = op_q;
          mem_addr   = addr_q;
          mem_datain = wdata_q;
        end
      endcase
    end
  end

  // second word of a crossing load lands above the first
  assign word64 = (step == 2'd0) ? {32'd0, mem_dataout}
                                 : {mem_dataout, lo_q};
  assign sh = 32'(word64 >> {addr_q[1:0], 3'b000});

  always_comb begin
    ld_res = 32'd0;
    unique case (1'b1)
      op_q == OP_B:  ld_res = {{24{sh[7]}}, sh[7:0]};
      op_q == OP_H:  ld_res = {{16{sh[15]}}, sh[15:0]};
      op_q == OP_W:  ld_res = sh;
      op_q == OP_BU: ld_res = {24'd0, sh[7:0]};
      op_q == OP_HU: ld_res = {16'd0, sh[15:0]};
      default:       ld_res = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rr_last <= 1'b1;
      gnt     <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      op_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      lo_q    <= 32'd0;
      rdata_q <= 32'd0;
      step    <= 2'd0;
      last_q  <= 2'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            gnt     <= gnt1;
            rr_last <= gnt1;
            we_q    <= s_we;
            op_q    <= s_op;
            addr_q  <= s_addr;
            wdata_q <= s_wdata;
            err_q   <= s_err;
            split_q <= s_split;
            last_q  <= s_last;
            step    <= 2'd0;
            rdata_q <= 32'd0;
            state   <= s_err ? S_DONE : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!we_q && step == 2'd0) lo_q <= mem_dataout;
          if (step == last_q) begin
            if (!we_q) rdata_q <= ld_res;
            state <= S_DONE;
          end else begin
            step <= step + 2'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic done0;
  logic done1;

  assign done0 = (state == S_DONE) && !gnt;
  assign done1 = (state == S_DONE) && gnt;

  assign r0.rvalid = done0;
  assign r0.rdata  = done0 ? rdata_q : 32'd0;
  assign r0.err    = done0 && err_q;
  assign r1.rvalid = done1;
  assign r1.rdata  = done1 ? rdata_q : 32'd0;
  assign r1.err    = done1 && err_q;
endmodule
